pixel_stream_source: RTL and testbench

//  Transmitter end of the Avalon-ST video pixel interface that video_sync_generator receives.
//  - Scans a grayscale framebuffer through the GPU-side read port of iomemory (1-cycle read latency).
//  - Emits pixels in raster order with valid/ready backpressure and startofpacket/endofpacket framing.
//  - Replaces the free-running valid='1 feed in the graphics path; sits between iomemory and the sync generator.

---
 rtl/pixel_stream_source_if.sv | 21 ++
 rtl/pixel_stream_source.sv | 181 ++++++++++++++++++
 tb/tb_pixel_stream_source.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_source_if.sv
// Avalon-ST video pixel stream between pixel_stream_source and video_sync_generator.
interface pixel_stream_source_if #(
  parameter int DATA_W = 8
) ();
  logic [3*DATA_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sop;
  logic                out_eop;
  logic                out_empty;

  modport master (
    output out_data, out_valid, out_sop, out_eop, out_empty,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sop, out_eop, out_empty,
    output out_ready
  );
endinterface

// File: rtl/pixel_stream_source.sv
// Raster-scans a grayscale framebuffer into an Avalon-ST pixel stream with sop/eop framing.
// Optional build macro TEST_PATTERN_EN adds a pattern_en port selecting a horizontal-ramp frame.
module pixel_stream_source #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_en,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  pixel_stream_source_if.master st,
  output logic              frame_done,
  output logic              busy
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int X_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [X_W-1:0]   LAST_X   = X_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [X_W-1:0]    x_q, x_d;
  logic              pat_q, pat_d;
  logic              inflight_q, inflight_d;
  logic              infl_sop_q, infl_sop_d;
  logic              infl_eop_q, infl_eop_d;
  logic [DATA_W-1:0] infl_pat_q, infl_pat_d;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              pattern_in;
  logic [CNT_W:0]    credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              start;
  entry_t            head;

`ifdef TEST_PATTERN_EN
  assign pattern_in = pattern_en;
`else
  assign pattern_in = 1'b0;
`endif

  // A read is only issued if its data is guaranteed a FIFO slot on capture.
  assign credit = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign issue  = (state_q == S_FETCH) && (credit < (CNT_W+1)'(FIFO_DEPTH));
  assign push   = inflight_q;
  assign pop    = (count_q != '0) && st.out_ready;
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    x_d        = x_q;
    pat_d      = pat_q;
    frame_done = 1'b0;
    start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          start   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          x_d   = (x_q == LAST_X) ? '0 : x_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_q == '0 && !inflight_q) begin
          frame_done = 1'b1;
          if (enable) begin
            start   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      base_d = base_addr;
      idx_d  = '0;
      x_d    = '0;
      pat_d  = pattern_in;
    end
  end

  always_comb begin
    inflight_d = issue;
    infl_sop_d = (idx_q == '0);
    infl_eop_d = (idx_q == LAST_IDX);
    infl_pat_d = DATA_W'(x_q);
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      fifo_d[wr_ptr_q].sop  = infl_sop_q;
      fifo_d[wr_ptr_q].eop  = infl_eop_q;
      fifo_d[wr_ptr_q].data = pat_q ? infl_pat_q : mem_rdata;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      pat_q      <= 1'b0;
      inflight_q <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      infl_pat_q <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      pat_q      <= pat_d;
      inflight_q <= inflight_d;
      infl_sop_q <= infl_sop_d;
      infl_eop_q <= infl_eop_d;
      infl_pat_q <= infl_pat_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count_q == DEPTH_C));

  assign mem_rd_en    = issue && !pat_q;
  assign mem_addr     = base_q + ADDR_W'(idx_q);
  assign st.out_valid = (count_q != '0);
  assign st.out_data  = st.out_valid ? {3{head.data}} : '0;
  assign st.out_sop   = st.out_valid && head.sop;
  assign st.out_eop   = st.out_valid && head.eop;
  assign st.out_empty = 1'b0;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source at 4x2 pixels, memory model mem[a] = a + 8'h10.
module tb_pixel_stream_source;
  localparam int NPIX = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [18:0] base_addr = '0;
  logic        mem_rd_en;
  logic [18:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        frame_done;
  logic        busy;
`ifdef TEST_PATTERN_EN
  logic        pattern_en = 1'b0;
`endif

  pixel_stream_source_if #(.DATA_W(8)) st ();

  pixel_stream_source #(
    .WIDTH(4), .HEIGHT(2), .ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(4)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .base_addr  (base_addr),
`ifdef TEST_PATTERN_EN
    .pattern_en (pattern_en),
`endif
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .st         (st),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [18:0] addr_log [$];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem_addr[7:0] + 8'h10;
      if (!reset) addr_log.push_back(mem_addr);
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] got_data [16];
  logic        got_sop  [16];
  logic        got_eop  [16];
  int          got_n, first_valid_at, eop_at, fd_at, fd_count;

  // Records accepted pixels; mode 0 keeps ready high, mode 1 toggles it 1010...
  task automatic collect(input int mode, input int budget);
    got_n = 0; first_valid_at = -1; eop_at = -1; fd_at = -1; fd_count = 0;
    for (int c = 0; c < budget && fd_at < 0; c++) begin
      @(negedge clk);
      st.out_ready = (mode == 0) ? 1'b1 : (c % 2 == 0);
      #1;
      if (frame_done) begin
        fd_count++;
        if (fd_at < 0) fd_at = c;
      end
      if (st.out_valid && first_valid_at < 0) first_valid_at = c;
      if (st.out_valid && st.out_ready) begin
        if (got_n < 16) begin
          got_data[got_n] = st.out_data;
          got_sop[got_n]  = st.out_sop;
          got_eop[got_n]  = st.out_eop;
        end
        if (st.out_eop) eop_at = c;
        got_n++;
      end
    end
  endtask

  task automatic start_frame(input logic [18:0] b, input logic pat);
    @(negedge clk);
    enable    = 1'b1;
    base_addr = b;
`ifdef TEST_PATTERN_EN
    pattern_en = pat;
`else
    if (pat) $display("note: pattern frame requested without TEST_PATTERN_EN");
`endif
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    st.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({st.out_valid, st.out_sop, st.out_eop, st.out_empty} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v/s/e/emp=%b required 0000",
               {st.out_valid, st.out_sop, st.out_eop, st.out_empty});
    end
    n_tests++;
    if (st.out_data !== 24'h0) begin
      n_fail++; $display("FAIL reset_data: got %h required 000000", st.out_data);
    end
    n_tests++;
    if ({mem_rd_en, frame_done, busy} !== 3'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got rd/fd/busy=%b required 000", {mem_rd_en, frame_done, busy});
    end
    n_tests++;
    if (mem_addr !== 19'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h required 00000", mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] first, input logic ramp);
    logic [7:0]  g;
    logic [23:0] exp;
    n_tests++;
    if (got_n != NPIX) begin
      n_fail++; $display("FAIL %s_count: got %0d pixels required %0d", name, got_n, NPIX);
    end
    for (int k = 0; k < NPIX && k < got_n; k++) begin
      g   = ramp ? 8'(k % 4) : first + 8'(k);
      exp = {g, g, g};
      n_tests++;
      if (got_data[k] !== exp || got_sop[k] !== (k == 0) || got_eop[k] !== (k == NPIX - 1)) begin
        n_fail++;
        $display("FAIL %s_pix%0d: got %h sop=%b eop=%b required %h sop=%b eop=%b",
                 name, k, got_data[k], got_sop[k], got_eop[k], exp, k == 0, k == NPIX - 1);
      end
    end
    n_tests++;
    if (fd_count != 1 || fd_at != eop_at + 1) begin
      n_fail++;
      $display("FAIL %s_frame_done: got count=%0d at=%0d required count=1 at=%0d",
               name, fd_count, fd_at, eop_at + 1);
    end
  endtask

  task automatic test_frame;
    st.out_ready = 1'b1;
    addr_log.delete();
    start_frame(19'h0, 1'b0);
    #1;
    n_tests++;
    if (busy !== 1'b1 || st.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latch_cycle: got busy=%b valid=%b required busy=1 valid=0", busy, st.out_valid);
    end
    collect(0, 40);
    n_tests++;
    if (first_valid_at != 1 || eop_at != first_valid_at + 7) begin
      n_fail++;
      $display("FAIL latency: got first=%0d eop=%0d required first=1 eop=8", first_valid_at, eop_at);
    end
    check_frame("basic", 8'h10, 1'b0);
    n_tests++;
    if (addr_log.size() != NPIX || addr_log[0] !== 19'h0 || addr_log[NPIX-1] !== 19'h7) begin
      n_fail++; $display("FAIL basic_addrs: got %0d reads required 8 from 0 to 7", addr_log.size());
    end
    @(negedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_frame: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure;
    int holds;
    holds = 0;
    st.out_ready = 1'b0;
    addr_log.delete();
    start_frame(19'h0, 1'b0);
    repeat (12) begin
      @(negedge clk); #1;
      if (st.out_valid) begin
        holds++;
        n_tests++;
        if (st.out_data !== 24'h101010 || st.out_sop !== 1'b1 || st.out_eop !== 1'b0) begin
          n_fail++;
          $display("FAIL hold: got %h sop=%b eop=%b required 101010 sop=1 eop=0",
                   st.out_data, st.out_sop, st.out_eop);
        end
      end
    end
    n_tests++;
    if (holds != 11) begin
      n_fail++; $display("FAIL hold_cycles: got %0d valid cycles required 11", holds);
    end
    n_tests++;
    if (addr_log.size() != 4 || mem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL credit: got %0d reads rd_en=%b required 4 reads rd_en=0", addr_log.size(), mem_rd_en);
    end
    collect(0, 40);
    check_frame("bp", 8'h10, 1'b0);
  endtask

  task automatic test_toggle;
    st.out_ready = 1'b1;
    start_frame(19'h0, 1'b0);
    collect(1, 60);
    check_frame("toggle", 8'h10, 1'b0);
  endtask

  task automatic test_wrap;
    logic [18:0] ea;
    st.out_ready = 1'b1;
    addr_log.delete();
    start_frame(19'h7FFFE, 1'b0);
    collect(0, 40);
    check_frame("wrap", 8'h0E, 1'b0);
    n_tests++;
    if (addr_log.size() != NPIX) begin
      n_fail++; $display("FAIL wrap_reads: got %0d reads required %0d", addr_log.size(), NPIX);
    end
    for (int k = 0; k < 4 && k < addr_log.size(); k++) begin
      ea = 19'h7FFFE + 19'(k);
      n_tests++;
      if (addr_log[k] !== ea) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %h required %h", k, addr_log[k], ea);
      end
    end
  endtask

  task automatic test_reset_mid;
    int  found;
    int  stray;
    found = 0;
    stray = 0;
    st.out_ready = 1'b1;
    start_frame(19'h0, 1'b0);
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk); #1;
      if (st.out_valid && st.out_data === 24'h121212) begin
        found = 1;
        reset = 1'b1;
      end
    end
    n_tests++;
    if (found == 0) begin
      n_fail++; $display("FAIL third_pixel: got no 121212 within budget required it");
    end
    @(negedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if (st.out_valid !== 1'b0 || busy !== 1'b0 || st.out_eop !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b eop=%b fd=%b required all 0",
               st.out_valid, busy, st.out_eop, frame_done);
    end
    repeat (4) begin
      @(negedge clk); #1;
      if (st.out_valid || frame_done || busy) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++; $display("FAIL after_reset_quiet: got %0d active cycles required 0", stray);
    end
    start_frame(19'h0, 1'b0);
    collect(0, 40);
    check_frame("restart", 8'h10, 1'b0);
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern;
    st.out_ready = 1'b1;
    addr_log.delete();
    start_frame(19'h0, 1'b1);
    pattern_en = 1'b0;
    collect(0, 40);
    check_frame("pattern", 8'h00, 1'b1);
    n_tests++;
    if (addr_log.size() != 0) begin
      n_fail++; $display("FAIL pattern_no_reads: got %0d reads required 0", addr_log.size());
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_frame;
    test_backpressure;
    test_toggle;
    test_wrap;
    test_reset_mid;
`ifdef TEST_PATTERN_EN
    test_pattern;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
